// File: rtl/video_timing_pkg.sv
// Shared timing constants, axis state encoding and segment-total helper
// for the video timing generator.
package video_timing_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FRONT_DEF  = 40;
    localparam int H_SYNC_DEF   = 128;
    localparam int H_BACK_DEF   = 88;
    localparam int V_ACTIVE_DEF = 600;
    localparam int V_FRONT_DEF  = 1;
    localparam int V_SYNC_DEF   = 4;
    localparam int V_BACK_DEF   = 23;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } axis_state_t;

    function automatic int seg_total(input int active, input int front,
                                     input int sync, input int back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: a wrapping counter plus its ACTIVE/FRONT/SYNC/BACK state.
// Everything moves only on cycles where advance is high.
module vtg_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FRONT  = H_FRONT_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BACK   = H_BACK_DEF,
    parameter int W      = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         advance,
    output logic [W-1:0] count,
    output axis_state_t  state,
    output logic         wrap
);

    localparam int TOTAL = seg_total(ACTIVE, FRONT, SYNC, BACK);
    localparam logic [W-1:0] END_ACTIVE = W'(ACTIVE - 1);
    localparam logic [W-1:0] END_FRONT  = W'(ACTIVE + FRONT - 1);
    localparam logic [W-1:0] END_SYNC   = W'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [W-1:0] END_TOTAL  = W'(TOTAL - 1);
    localparam logic [W-1:0] ONE        = W'(1);

    // Counter and segment state advance together so state always matches count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            state <= ST_ACTIVE;
        end else if (advance) begin
            if (count == END_TOTAL) begin
                count <= '0;
            end else begin
                count <= count + ONE;
            end
            case (state)
                ST_ACTIVE: if (count == END_ACTIVE) state <= ST_FRONT;
                ST_FRONT:  if (count == END_FRONT)  state <= ST_SYNC;
                ST_SYNC:   if (count == END_SYNC)   state <= ST_BACK;
                ST_BACK:   if (count == END_TOTAL)  state <= ST_ACTIVE;
                default:   state <= ST_ACTIVE;
            endcase
        end
    end

    assign wrap = advance && (count == END_TOTAL);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered coordinates, enable and syncs.
// Optional frame_start/frame_cnt outputs are built when VTG_FRAME_CNT_EN is defined.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] gr_x,
    output logic [9:0]  gr_y,
    output logic        enable,
    output logic        hsync,
    output logic        vsync
`ifdef VTG_FRAME_CNT_EN
    ,
    output logic        frame_start,
    output logic [15:0] frame_cnt
`endif
);

    logic [10:0] h_cnt_s;
    logic [9:0]  v_cnt_s;
    axis_state_t h_state_s;
    axis_state_t v_state_s;
    logic        h_wrap_s;
    logic        v_wrap_s;
    logic        v_wrap_unused_s;

    vtg_axis_counter #(
        .ACTIVE (H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(11)
    ) u_h_axis (
        .clk     (clk),
        .reset   (reset),
        .advance (1'b1),
        .count   (h_cnt_s),
        .state   (h_state_s),
        .wrap    (h_wrap_s)
    );

    vtg_axis_counter #(
        .ACTIVE (V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(10)
    ) u_v_axis (
        .clk     (clk),
        .reset   (reset),
        .advance (h_wrap_s),
        .count   (v_cnt_s),
        .state   (v_state_s),
        .wrap    (v_wrap_s)
    );

    assign v_wrap_unused_s = v_wrap_s;

    // Output stage: one register level so all outputs switch on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            gr_x   <= 11'd0;
            gr_y   <= 10'd0;
            enable <= 1'b0;
            hsync  <= ~H_POL;
            vsync  <= ~V_POL;
        end else begin
            gr_x   <= h_cnt_s;
            gr_y   <= v_cnt_s;
            enable <= (h_state_s == ST_ACTIVE) && (v_state_s == ST_ACTIVE);
            hsync  <= (h_state_s == ST_SYNC) ? H_POL : ~H_POL;
            vsync  <= (v_state_s == ST_SYNC) ? V_POL : ~V_POL;
        end
    end

`ifdef VTG_FRAME_CNT_EN
    logic first_seen_r;

    // The first (0,0) after reset marks frame zero, so it pulses without counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_start  <= 1'b0;
            frame_cnt    <= 16'd0;
            first_seen_r <= 1'b0;
        end else begin
            frame_start <= (h_cnt_s == 11'd0) && (v_cnt_s == 10'd0);
            if ((h_cnt_s == 11'd0) && (v_cnt_s == 10'd0)) begin
                first_seen_r <= 1'b1;
                if (first_seen_r) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: a default-timing instance and a small inverted-polarity
// instance, each checked every cycle against a reference raster model.
module tb_video_timing_gen;

    localparam int A_HA = 800, A_HF = 40, A_HS = 128, A_HB = 88;
    localparam int A_VA = 600, A_VF = 1,  A_VS = 4,   A_VB = 23;
    localparam bit A_HP = 1'b1, A_VP = 1'b1;
    localparam int B_HA = 16,  B_HF = 2,  B_HS = 4,   B_HB = 3;
    localparam int B_VA = 10,  B_VF = 1,  B_VS = 2,   B_VB = 3;
    localparam bit B_HP = 1'b0, B_VP = 1'b0;
    localparam int A_HT = 1056, A_VT = 628;
    localparam int B_HT = 25,   B_VT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] gr_x_a, gr_x_b;
    logic [9:0]  gr_y_a, gr_y_b;
    logic        en_a, hs_a, vs_a, en_b, hs_b, vs_b;
`ifdef VTG_FRAME_CNT_EN
    logic        fs_a, fs_b;
    logic [15:0] fc_a, fc_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int mxa = 0, mya = 0, mxb = 0, myb = 0;
    logic [23:0] q_a[$];
    logic [23:0] q_b[$];
`ifdef VTG_FRAME_CNT_EN
    int fcnt_a = 0, fcnt_b = 0;
    bit first_a = 1'b1, first_b = 1'b1;
    logic [16:0] qf_a[$];
    logic [16:0] qf_b[$];
`endif

    always #5 clk = ~clk;

    video_timing_gen u_dut_a (
        .clk(clk), .reset(reset), .gr_x(gr_x_a), .gr_y(gr_y_a),
        .enable(en_a), .hsync(hs_a), .vsync(vs_a)
`ifdef VTG_FRAME_CNT_EN
        , .frame_start(fs_a), .frame_cnt(fc_a)
`endif
    );

    video_timing_gen #(
        .H_ACTIVE(B_HA), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_ACTIVE(B_VA), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
        .H_POL(B_HP), .V_POL(B_VP)
    ) u_dut_b (
        .clk(clk), .reset(reset), .gr_x(gr_x_b), .gr_y(gr_y_b),
        .enable(en_b), .hsync(hs_b), .vsync(vs_b)
`ifdef VTG_FRAME_CNT_EN
        , .frame_start(fs_b), .frame_cnt(fc_b)
`endif
    );

    function automatic logic [23:0] exp_pix(input int x, input int y,
            input int ha, input int hf, input int hs, input int va, input int vf,
            input int vs, input bit hp, input bit vp);
        logic e, h, v;
        e = (x < ha) && (y < va);
        h = (x >= ha + hf && x < ha + hf + hs) ? hp : ~hp;
        v = (y >= va + vf && y < va + vf + vs) ? vp : ~vp;
        return {11'(x), 10'(y), e, h, v};
    endfunction

    // One clock: push model expectations, clock, pop and compare both instances.
    task automatic step(input string tag);
        logic [23:0] ea, eb, oa, ob;
`ifdef VTG_FRAME_CNT_EN
        logic [16:0] efa, efb, ofa, ofb;
        if (reset) begin
            fcnt_a = 0; fcnt_b = 0; first_a = 1'b1; first_b = 1'b1;
            qf_a.push_back(17'd0); qf_b.push_back(17'd0);
        end else begin
            if (mxa == 0 && mya == 0) begin
                if (!first_a) fcnt_a = (fcnt_a + 1) % 65536;
                first_a = 1'b0;
            end
            if (mxb == 0 && myb == 0) begin
                if (!first_b) fcnt_b = (fcnt_b + 1) % 65536;
                first_b = 1'b0;
            end
            qf_a.push_back({(mxa == 0 && mya == 0) ? 1'b1 : 1'b0, 16'(fcnt_a)});
            qf_b.push_back({(mxb == 0 && myb == 0) ? 1'b1 : 1'b0, 16'(fcnt_b)});
        end
`endif
        if (reset) begin
            q_a.push_back({11'd0, 10'd0, 1'b0, ~A_HP, ~A_VP});
            q_b.push_back({11'd0, 10'd0, 1'b0, ~B_HP, ~B_VP});
            mxa = 0; mya = 0; mxb = 0; myb = 0;
        end else begin
            q_a.push_back(exp_pix(mxa, mya, A_HA, A_HF, A_HS, A_VA, A_VF, A_VS, A_HP, A_VP));
            q_b.push_back(exp_pix(mxb, myb, B_HA, B_HF, B_HS, B_VA, B_VF, B_VS, B_HP, B_VP));
            mxa++; if (mxa == A_HT) begin mxa = 0; mya++; if (mya == A_VT) mya = 0; end
            mxb++; if (mxb == B_HT) begin mxb = 0; myb++; if (myb == B_VT) myb = 0; end
        end
        @(posedge clk);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        oa = {gr_x_a, gr_y_a, en_a, hs_a, vs_a};
        ob = {gr_x_b, gr_y_b, en_b, hs_b, vs_b};
        n_tests++;
        if (oa !== ea) begin
            n_fail++;
            $display("FAIL %s dut_a raster: got %h expected %h", tag, oa, ea);
        end
        n_tests++;
        if (ob !== eb) begin
            n_fail++;
            $display("FAIL %s dut_b raster: got %h expected %h", tag, ob, eb);
        end
`ifdef VTG_FRAME_CNT_EN
        efa = qf_a.pop_front();
        efb = qf_b.pop_front();
        ofa = {fs_a, fc_a};
        ofb = {fs_b, fc_b};
        n_tests++;
        if (ofa !== efa) begin
            n_fail++;
            $display("FAIL %s dut_a frame: got %h expected %h", tag, ofa, efa);
        end
        n_tests++;
        if (ofb !== efb) begin
            n_fail++;
            $display("FAIL %s dut_b frame: got %h expected %h", tag, ofb, efb);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step("reset_hold");
        n_tests++;
        if ({gr_x_a, gr_y_a, en_a, hs_a, vs_a} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected 000000", {gr_x_a, gr_y_a, en_a, hs_a, vs_a});
        end
        reset = 1'b0;
        step("reset_release");
        n_tests++;
        if (en_a !== 1'b1 || gr_x_a !== 11'd0 || gr_y_a !== 10'd0) begin
            n_fail++;
            $display("FAIL first_pixel: got en=%b x=%0d y=%0d expected en=1 x=0 y=0", en_a, gr_x_a, gr_y_a);
        end
    endtask

    task automatic test_line();
        int px, py, fall_x, hs_len, hs_start;
        bit pe, ph, wrapped;
        fall_x = -1; hs_len = 0; hs_start = -1; wrapped = 1'b0;
        for (int i = 0; i < A_HT; i++) begin
            px = gr_x_a; py = gr_y_a; pe = en_a; ph = hs_a;
            step("line");
            if (pe && !en_a && fall_x < 0 && px == 799) fall_x = gr_x_a;
            if (hs_a) hs_len++;
            if (!ph && hs_a && hs_start < 0) hs_start = gr_x_a;
            if (px == 1055 && gr_x_a == 11'd0 && py == 0 && gr_y_a == 10'd1) wrapped = 1'b1;
        end
        n_tests++;
        if (fall_x != 800) begin n_fail++; $display("FAIL enable_fall: got x=%0d expected 800", fall_x); end
        n_tests++;
        if (hs_len != 128) begin n_fail++; $display("FAIL hsync_width: got %0d expected 128", hs_len); end
        n_tests++;
        if (hs_start != 840) begin n_fail++; $display("FAIL hsync_start: got %0d expected 840", hs_start); end
        n_tests++;
        if (!wrapped) begin n_fail++; $display("FAIL line_wrap: got no 1055->0 wrap expected wrap with y 0->1"); end
    endtask

    task automatic test_frame();
        int py, vs_len, vs_sx, vs_sy, f0, f1, cyc;
        bit pv, in_run, run_done, ywrap;
        vs_len = 0; vs_sx = -1; vs_sy = -1; f0 = -1; f1 = -1;
        in_run = 1'b0; run_done = 1'b0; ywrap = 1'b0; cyc = 0;
        for (int i = 0; i < 2 * B_HT * B_VT; i++) begin
            py = gr_y_b; pv = vs_b;
            step("frame");
            cyc++;
            if (pv && !vs_b && !run_done) begin in_run = 1'b1; vs_sx = gr_x_b; vs_sy = gr_y_b; end
            if (in_run && !vs_b) vs_len++;
            if (in_run && vs_b) begin in_run = 1'b0; run_done = 1'b1; end
            if (py == B_VT - 1 && gr_y_b == 10'd0) ywrap = 1'b1;
            if (gr_x_b == 11'd0 && gr_y_b == 10'd0) begin
                if (f0 < 0) f0 = cyc; else if (f1 < 0) f1 = cyc;
            end
        end
        n_tests++;
        if (vs_len != B_VS * B_HT) begin n_fail++; $display("FAIL vsync_width: got %0d expected %0d", vs_len, B_VS * B_HT); end
        n_tests++;
        if (vs_sx != 0 || vs_sy != B_VA + B_VF) begin
            n_fail++; $display("FAIL vsync_start: got (%0d,%0d) expected (0,%0d)", vs_sx, vs_sy, B_VA + B_VF);
        end
        n_tests++;
        if (!ywrap) begin n_fail++; $display("FAIL frame_wrap: got no y wrap expected %0d->0", B_VT - 1); end
        n_tests++;
        if (f1 - f0 != B_HT * B_VT) begin n_fail++; $display("FAIL frame_len: got %0d expected %0d", f1 - f0, B_HT * B_VT); end
    endtask

    task automatic test_polarity();
        int hs_len, hs_start;
        bit ph, in_run, done;
        hs_len = 0; hs_start = -1; in_run = 1'b0; done = 1'b0;
        for (int i = 0; i < 2 * B_HT; i++) begin
            ph = hs_b;
            step("polarity");
            if (ph && !hs_b && !done) begin in_run = 1'b1; hs_start = gr_x_b; end
            if (in_run && !hs_b) hs_len++;
            if (in_run && hs_b) begin in_run = 1'b0; done = 1'b1; end
        end
        n_tests++;
        if (hs_len != B_HS || hs_start != B_HA + B_HF) begin
            n_fail++;
            $display("FAIL hsync_low_pol: got len=%0d start=%0d expected len=%0d start=%0d", hs_len, hs_start, B_HS, B_HA + B_HF);
        end
    endtask

    task automatic test_mid_reset();
        bit hit;
        int len;
        hit = 1'b0;
        for (int i = 0; i < B_HT * B_VT && !hit; i++) begin
            step("mid_seek");
            if (gr_x_b == 11'd7 && gr_y_b == 10'd5) hit = 1'b1;
        end
        n_tests++;
        if (!hit) begin n_fail++; $display("FAIL mid_seek: got no (7,5) expected within one frame"); end
        reset = 1'b1;
        step("mid_reset");
        reset = 1'b0;
        step("mid_restart");
        n_tests++;
        if (en_b !== 1'b1 || gr_x_b !== 11'd0 || gr_y_b !== 10'd0) begin
            n_fail++;
            $display("FAIL mid_restart: got en=%b x=%0d y=%0d expected en=1 x=0 y=0", en_b, gr_x_b, gr_y_b);
        end
        len = -1;
        for (int i = 1; i <= A_HT + 8 && len < 0; i++) begin
            step("mid_line");
            if (gr_x_a == 11'd0) len = i;
        end
        n_tests++;
        if (len != A_HT) begin n_fail++; $display("FAIL mid_line_len: got %0d expected %0d", len, A_HT); end
    endtask

`ifdef VTG_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int pulses, idx[3];
        pulses = 0;
        reset = 1'b1;
        step("fcnt_reset");
        reset = 1'b0;
        for (int i = 0; i < 3 * B_HT * B_VT; i++) begin
            step("fcnt");
            if (fs_b === 1'b1) begin
                if (pulses < 3) idx[pulses] = i;
                pulses++;
                if (pulses == 3) begin
                    n_tests++;
                    if (fc_b !== 16'd2) begin n_fail++; $display("FAIL fcnt_third: got %0d expected 2", fc_b); end
                end
            end
        end
        n_tests++;
        if (pulses != 3) begin n_fail++; $display("FAIL fcnt_pulses: got %0d expected 3", pulses); end
        n_tests++;
        if (pulses >= 3 && (idx[0] != 0 || idx[1] - idx[0] != B_HT * B_VT || idx[2] - idx[1] != B_HT * B_VT)) begin
            n_fail++;
            $display("FAIL fcnt_spacing: got %0d,%0d,%0d expected 0,%0d,%0d", idx[0], idx[1], idx[2], B_HT * B_VT, 2 * B_HT * B_VT);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_polarity();
        test_mid_reset();
`ifdef VTG_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Video timing generator for the fish-counter display path. It produces the raster coordinates `gr_x`/`gr_y`, the active-video `enable`, and `hsync`/`vsync` that drive the number-box overlay stage and the VGA output pins. All outputs are registered and mutually aligned, so downstream stages compare coordinates against constants with no skew correction.

## Interface
- `H_ACTIVE`, 800, visible pixels per line
- `H_FRONT`, 40, horizontal front porch (clocks)
- `H_SYNC`, 128, horizontal sync width
- `H_BACK`, 88, horizontal back porch
- `V_ACTIVE`, 600, visible lines per frame
- `V_FRONT`, 1, vertical front porch (lines)
- `V_SYNC`, 4, vertical sync width
- `V_BACK`, 23, vertical back porch
- `H_POL`, 1, hsync active level
- `V_POL`, 1, vsync active level
- `clk`  in  1  pixel clock (40 MHz for the defaults)
- `reset`  in  1  synchronous, active-high reset
- `gr_x`  out  11  horizontal count, 0..H_TOTAL-1
- `gr_y`  out  10  vertical count, 0..V_TOTAL-1
- `enable`  out  1  high while `gr_x < H_ACTIVE` and `gr_y < V_ACTIVE`
- `hsync`  out  1  horizontal sync, level `H_POL` when active
- `vsync`  out  1  vertical sync, level `V_POL` when active
- `frame_start`  out  1  one-cycle pulse with pixel (0,0); present only with `VTG_FRAME_CNT_EN`
- `frame_cnt`  out  16  frames completed since reset; present only with `VTG_FRAME_CNT_EN`

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (default 1056). V_TOTAL is built the same way (default 628).
- Legal ranges: H_TOTAL ≤ 2047 and V_TOTAL ≤ 1023. Every porch and sync parameter is ≥ 1.
- Internal `h_cnt` increments every clock. When it reaches H_TOTAL-1 it wraps to 0 and `v_cnt` advances.
- `v_cnt` wraps from V_TOTAL-1 to 0 on the same clock that `h_cnt` wraps.
- Each axis runs a state machine: ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - ACTIVE ends at count ACTIVE-1.
  - FRONT ends at ACTIVE+FRONT-1.
  - SYNC ends at ACTIVE+FRONT+SYNC-1.
  - BACK ends at TOTAL-1.
- Vertical state changes only on a horizontal wrap.
- `enable` = (h state ACTIVE) AND (v state ACTIVE).
- `hsync` = H_POL while h state is SYNC, otherwise ~H_POL. `vsync` follows the same rule with V_POL.
- With the defaults:
  - `hsync` is active for `gr_x` 840..967.
  - `vsync` is active for `gr_y` 601..604, across the whole of each of those lines.
- `gr_x`/`gr_y` carry the raw counts in blanking too. Consumers gate on `enable`.
- Reset values:
  - `gr_x`=0, `gr_y`=0, `enable`=0
  - `hsync`=~H_POL, `vsync`=~V_POL
  - `frame_start`=0, `frame_cnt`=0
  - both state machines in ACTIVE, counters 0
- Reset mid-frame aborts the raster immediately. Scanning restarts at (0,0) with no partial-line completion.

## Timing
- Outputs are registered from the counter/state decode, one clock behind the internal counters.
- The first clock edge with `reset` low outputs pixel (0,0): `enable`=1, `gr_x`=0, `gr_y`=0.
- Line period: H_TOTAL clocks. Frame period: H_TOTAL×V_TOTAL clocks (663168 with the defaults).
- All five outputs change on the same edge. No output is combinational from an input.

## Configuration
- `VTG_FRAME_CNT_EN` defined:
  - Adds `frame_start`, high for exactly the cycle where the outputs show (0,0), including the first cycle after reset.
  - Adds `frame_cnt`, which increments on the same edge that `frame_start` rises for every frame except the first after reset, and wraps at 65535→0.
- `VTG_FRAME_CNT_EN` undefined: both ports and their logic are absent, and the remaining behaviour is identical.

## Structure
- Shared package `video_timing_pkg`:
  - default timing constants
  - axis state encoding (ACTIVE, FRONT, SYNC, BACK, 2 bits)
  - a function computing TOTAL from the four segment lengths
- One sub-module, `vtg_axis_counter`, instantiated twice (horizontal, vertical):
  - ports: `clk`, `reset`, `advance`, plus segment parameters
  - outputs: `count`, `state`, and a `wrap` pulse
  - horizontal instance: `advance` tied to 1
  - vertical instance: `advance` fed by the horizontal `wrap`

## Test plan
- Reset: hold `reset` 5 cycles, sample outputs → `gr_x`=0, `gr_y`=0, `enable`=0, `hsync`=0, `vsync`=0. Release → next edge shows `enable`=1 at (0,0).
- Line timing: run 1056 cycles → `enable` falls when `gr_x` goes 799→800. `hsync` is high for exactly 128 cycles starting at `gr_x`=840. `gr_x` wraps 1055→0 as `gr_y` goes 0→1.
- Frame timing: run one frame → `vsync` is high for 4×1056 cycles starting at (0,601). `gr_y` wraps 627→0. Frame length is 663168 cycles.
- Reset mid-frame: assert `reset` at (400,300) for 1 cycle → outputs return to reset values, then restart at (0,0) with a full-length line.
- Polarity: H_POL=0, V_POL=0 → sync levels are inverted, and sync positions are unchanged.
- With `VTG_FRAME_CNT_EN`: run 3 frames → `frame_start` pulses 3 times, 663168 cycles apart, and `frame_cnt` reads 2 during the third frame.
